ita_activation: RTL and testbench
=================================

# ita_activation

N-lane elastic activation stage between the output requantizer and the output FIFO. It takes one beat of N `requant_t` lanes at a time and applies the selected activation: identity, ReLU or GELU. It runs at full throughput with valid/ready handshakes, and a beat counter generates tile boundaries. Activation constants are latched through a configuration write and held for the whole tile.

## Interface
- `N`, 16, lanes per beat
- `CNT_W`, 16, width of the beat counter and tile-length field
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, synchronous active-low
- `cfg_we_i` in 1: configuration write strobe
- `cfg_mode_i` in 2: `activation_e` (0 IDENTITY, 1 RELU, 2 GELU, 3 reserved → IDENTITY)
- `cfg_one_i`, `cfg_b_i`, `cfg_c_i` in `GELU_CONSTANTS_WIDTH`: GELU polynomial constants
- `cfg_eps_mult_i`, `cfg_right_shift_i` in `EMS`: GELU requant multiplier and shift
- `cfg_add_i` in `WI`: GELU requant offset
- `cfg_len_i` in `CNT_W`: beats per tile; 0 is treated as 1
- `cfg_err_o` out 1: one-cycle pulse when a config write is rejected
- `valid_i` in 1, `ready_o` out 1, `data_i` in N×`WI`: input beat
- `valid_o` out 1, `ready_i` in 1, `data_o` out N×`WI`, `last_o` out 1: output beat
- `busy_o` out 1: any pipeline stage holds a beat
- `sat_cnt_o` out 16: GELU saturation count (see Configuration)

## Operation
- **Config register:**
  - A write is accepted when `cfg_we_i` is high and `busy_o` and `valid_i` are both low.
  - An accepted write loads all `cfg_*` fields and clears the beat counter.
  - A write in any other case is ignored, and `cfg_err_o` pulses for one cycle.
- **Pipeline:** two register stages, S1 and S2.
  - S1 captures `data_i` on input handshake (`valid_i & ready_o`).
  - S2 captures the per-lane activation of S1 when S1 advances.
- **Lane function:**
  - IDENTITY: out = x.
  - RELU: out = x < 0 ? 0 : x.
  - GELU: clip x below to −127, then apply the polynomial erf approximation, multiply by x, multiply by `eps_mult`, arithmetic right shift by `right_shift`, round half away from zero, add `add`, and saturate to [−128, 127].
  - All intermediate GELU products are kept at `GELU_PRE_RQS_WIDTH+EMS` bits before saturation.
- **Beat counter:**
  - Increments on each output handshake.
  - When count == len−1: `last_o` is high, and on handshake the counter wraps to 0.
  - `last_o` is combinational from the counter and `valid_o`.
- **Reserved mode:** mode 3 behaves as IDENTITY.

## Timing
- **Reset values:** `valid_o` 0, `ready_o` 1, `data_o` 0, `last_o` 0, `busy_o` 0, `cfg_err_o` 0, `sat_cnt_o` 0, counter 0, config mode IDENTITY, len 1, all constants 0.
- **Latency:** 2 cycles from input handshake to `valid_o`, with `ready_i` held high.
- **Throughput:** 1 beat/cycle.
- **Stall propagation:**
  - `ready_o` = ~S1.valid | s1_adv.
  - s1_adv = S1.valid & (~S2.valid | `ready_i`).
  - Combinational ready path only; no bubbles.
- **Output stability:** while `valid_o & ~ready_i`, `data_o` and `last_o` are held stable.
- **Same-cycle handshakes:** input and output handshakes in the same cycle are both honoured; occupancy is unchanged.
- **Config timing:** config changes affect only beats entering S1 after the write. This follows by construction, since writes require an empty pipe.
- **Reset mid-operation:** `rst_ni` low for one clock edge drops all in-flight beats, clears the counter and restores the config defaults. Nothing is emitted afterwards.
- **Counter wrap:** len = 65535 wraps correctly, and len 0 or 1 asserts `last_o` on every beat.

## Configuration
- **Macro:** `ITA_ACT_SAT_CNT_EN`.
- **Defined:**
  - `sat_cnt_o` counts lanes that saturated in the GELU path (pre-saturation value outside [−128, 127]) on S2 capture, summed over lanes per cycle.
  - The count sticks at 0xFFFF.
  - It is cleared by an accepted config write or by reset.
- **Undefined:** `sat_cnt_o` is tied to 0 and no counter logic is synthesised.

## Structure
- **In `ita_package`:**
  - `activation_e`.
  - An `activation_cfg_t` struct holding mode, one, b, c, eps_mult, right_shift, add and len.
  - `WI`, `EMS`, `GELU_CONSTANTS_WIDTH`, `GELU_PRE_RQS_WIDTH` (existing).
- **Sub-module:** the per-lane GELU is existing `ita_gelu`, instantiated N times. Its pre-saturation overflow is recomputed locally for the stats counter.
- **Everything else inline:** handshake, counter and config.

## Test plan
- **Identity throughput:** mode IDENTITY, len 4, `ready_i`=1, stream 8 beats with lane0 = 0..7 → outputs appear 2 cycles later, one per cycle, with `last_o` on beats 3 and 7.
- **ReLU:** mode RELU, lanes {−5, 0, 7, −128} → {0, 0, 7, 0}.
- **GELU:** one=16, b=−4, c=14, eps=1, shift=2, add=0.
  - x=2 → 17.
  - x=−2 → 1.
  - Same constants with shift=0: x=127 → 127 (saturated), and `sat_cnt_o` increments when the macro is defined.
- **Backpressure:** `ready_i` low for 5 cycles mid-stream.
  - Exactly 2 beats are held.
  - `ready_o` drops in the cycle after S1 fills.
  - `data_o` is stable throughout.
  - No loss or duplication after release.
- **Rejected config:** `cfg_we_i` while `busy_o`=1 → `cfg_err_o` pulse, mode unchanged.
- **Reset mid-stream:** `rst_ni` low for 1 cycle with both stages full → `valid_o`=0 next cycle and counter 0; the next tile's `last_o` lands at beat len−1.

Source files
------------

// File: rtl/ita_package.sv
`default_nettype none
// ============================================================================
// Module   : ita_package
// Brief    : Shared widths, activation types and the GELU reference datapath.
// Revision : 1.0
// ============================================================================
package ita_package;

   localparam int WI                   = 8;
   localparam int EMS                  = 8;
   localparam int GELU_CONSTANTS_WIDTH = 16;
   localparam int GELU_PRE_RQS_WIDTH   = 32;

   localparam int c_act_len_w   = 16;
   localparam int c_gelu_wide_w = GELU_PRE_RQS_WIDTH + EMS;

   typedef logic signed [WI-1:0]                   requant_t;
   typedef logic signed [GELU_CONSTANTS_WIDTH-1:0] gelu_const_t;
   typedef logic signed [c_gelu_wide_w-1:0]        gelu_wide_t;

   typedef enum logic [1:0] {
      ACT_IDENTITY = 2'd0,
      ACT_RELU     = 2'd1,
      ACT_GELU     = 2'd2,
      ACT_RESERVED = 2'd3
   } activation_e;

   typedef struct packed {
      activation_e            mode;
      gelu_const_t            one;
      gelu_const_t            b;
      gelu_const_t            c;
      logic [EMS-1:0]         eps_mult;
      logic [EMS-1:0]         right_shift;
      requant_t               add;
      logic [c_act_len_w-1:0] len;
   } activation_cfg_t;

   localparam activation_cfg_t c_act_cfg_default = '{
      mode:        ACT_IDENTITY,
      one:         '0,
      b:           '0,
      c:           '0,
      eps_mult:    '0,
      right_shift: '0,
      add:         '0,
      len:         c_act_len_w'(1)
   };

   localparam gelu_wide_t c_wide_zero   = gelu_wide_t'(0);
   localparam gelu_wide_t c_wide_one    = gelu_wide_t'(1);
   localparam gelu_wide_t c_requant_max = gelu_wide_t'(2 ** (WI - 1) - 1);
   localparam gelu_wide_t c_requant_min = gelu_wide_t'(-(2 ** (WI - 1)));
   localparam gelu_wide_t c_gelu_clip   = gelu_wide_t'(1 - 2 ** (WI - 1));

   // GELU up to (but excluding) the final saturation; shared by the lane
   // datapath and the saturation statistics so both agree bit for bit.
   function automatic gelu_wide_t gelu_presat(
      input requant_t       x,
      input gelu_const_t    one,
      input gelu_const_t    b,
      input gelu_const_t    c,
      input logic [EMS-1:0] eps_mult,
      input logic [EMS-1:0] right_shift,
      input requant_t       add
   );
      gelu_wide_t xc, xa, lim, d, erf, q, p, mag;
      xc = gelu_wide_t'(x);
      if (xc < c_gelu_clip) xc = c_gelu_clip;
      xa  = (xc < c_wide_zero) ? -xc : xc;
      lim = -gelu_wide_t'(b);
      if (xa > lim) xa = lim;
      d   = xa + gelu_wide_t'(b);
      erf = d * d + gelu_wide_t'(c);
      if (xc < c_wide_zero) erf = -erf;
      q   = xc * (erf + gelu_wide_t'(one));
      p   = q * gelu_wide_t'(eps_mult);
      mag = (p < c_wide_zero) ? -p : p;
      if (right_shift != '0)
         mag = (mag + (c_wide_one <<< (right_shift - EMS'(1)))) >>> right_shift;
      return ((p < c_wide_zero) ? -mag : mag) + gelu_wide_t'(add);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ita_gelu.sv
`default_nettype none
// ============================================================================
// Module   : ita_gelu
// Brief    : Single-lane combinational i-GELU with requantization and saturation.
// Revision : 1.0
// ============================================================================
module ita_gelu
   import ita_package::*;
(
   input  logic signed [WI-1:0]                   data_i,
   input  logic signed [GELU_CONSTANTS_WIDTH-1:0] one_i,
   input  logic signed [GELU_CONSTANTS_WIDTH-1:0] b_i,
   input  logic signed [GELU_CONSTANTS_WIDTH-1:0] c_i,
   input  logic        [EMS-1:0]                  eps_mult_i,
   input  logic        [EMS-1:0]                  right_shift_i,
   input  logic signed [WI-1:0]                   add_i,
   output logic signed [WI-1:0]                   data_o
);

   gelu_wide_t w_presat;

   assign w_presat = gelu_presat(data_i, one_i, b_i, c_i, eps_mult_i, right_shift_i, add_i);

   always_comb begin
      if (w_presat > c_requant_max)
         data_o = requant_t'(c_requant_max);
      else if (w_presat < c_requant_min)
         data_o = requant_t'(c_requant_min);
      else
         data_o = w_presat[WI-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/ita_activation.sv
`default_nettype none
// ============================================================================
// Module   : ita_activation
// Brief    : N-lane elastic identity/ReLU/GELU stage with tile beat counter.
//            Define ITA_ACT_SAT_CNT_EN to enable the GELU saturation counter.
// Revision : 1.0
// ============================================================================
module ita_activation
   import ita_package::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   cfg_we_i,
   input  logic [1:0]                             cfg_mode_i,
   input  logic signed [GELU_CONSTANTS_WIDTH-1:0] cfg_one_i,
   input  logic signed [GELU_CONSTANTS_WIDTH-1:0] cfg_b_i,
   input  logic signed [GELU_CONSTANTS_WIDTH-1:0] cfg_c_i,
   input  logic        [EMS-1:0]                  cfg_eps_mult_i,
   input  logic        [EMS-1:0]                  cfg_right_shift_i,
   input  logic signed [WI-1:0]                   cfg_add_i,
   input  logic        [CNT_W-1:0]                cfg_len_i,
   output logic                                   cfg_err_o,
   input  logic                                   valid_i,
   output logic                                   ready_o,
   input  logic [N-1:0][WI-1:0]                   data_i,
   output logic                                   valid_o,
   input  logic                                   ready_i,
   output logic [N-1:0][WI-1:0]                   data_o,
   output logic                                   last_o,
   output logic                                   busy_o,
   output logic [15:0]                            sat_cnt_o
);

   activation_cfg_t         r_cfg;
   logic                    r_cfg_err;
   logic                    r_s1_valid;
   logic                    r_s2_valid;
   logic [N-1:0][WI-1:0]    r_s1_data;
   logic [N-1:0][WI-1:0]    r_s2_data;
   logic [N-1:0][WI-1:0]    w_act;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_len;
   logic [CNT_W-1:0]        w_len_m1;
   logic                    w_cfg_accept;
   logic                    w_in_hs;
   logic                    w_out_hs;
   logic                    w_s1_adv;
   logic                    w_last;

   assign busy_o       = r_s1_valid | r_s2_valid;
   assign w_cfg_accept = cfg_we_i & ~busy_o & ~valid_i;
   assign w_s1_adv     = r_s1_valid & (~r_s2_valid | ready_i);
   assign ready_o      = ~r_s1_valid | w_s1_adv;
   assign w_in_hs      = valid_i & ready_o;
   assign w_out_hs     = r_s2_valid & ready_i;

   // A zero tile length behaves like a length of one.
   assign w_len    = r_cfg.len[CNT_W-1:0];
   assign w_len_m1 = (w_len == '0) ? '0 : w_len - CNT_W'(1);
   assign w_last   = r_s2_valid & (r_cnt == w_len_m1);

   assign valid_o   = r_s2_valid;
   assign data_o    = r_s2_data;
   assign last_o    = w_last;
   assign cfg_err_o = r_cfg_err;

   for (genvar i = 0; i < int'(N); i++) begin : g_lane
      logic signed [WI-1:0] w_gelu;

      ita_gelu u_gelu (
         .data_i        (r_s1_data[i]),
         .one_i         (r_cfg.one),
         .b_i           (r_cfg.b),
         .c_i           (r_cfg.c),
         .eps_mult_i    (r_cfg.eps_mult),
         .right_shift_i (r_cfg.right_shift),
         .add_i         (r_cfg.add),
         .data_o        (w_gelu)
      );

      assign w_act[i] = (r_cfg.mode == ACT_GELU)                       ? w_gelu :
                        ((r_cfg.mode == ACT_RELU) && r_s1_data[i][WI-1]) ? '0     :
                                                                           r_s1_data[i];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cfg      <= c_act_cfg_default;
         r_cfg_err  <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s2_data  <= '0;
         r_cnt      <= '0;
      end else begin
         r_cfg_err <= cfg_we_i & ~w_cfg_accept;
         if (w_cfg_accept) begin
            r_cfg <= '{
               mode:        activation_e'(cfg_mode_i),
               one:         cfg_one_i,
               b:           cfg_b_i,
               c:           cfg_c_i,
               eps_mult:    cfg_eps_mult_i,
               right_shift: cfg_right_shift_i,
               add:         cfg_add_i,
               len:         c_act_len_w'(cfg_len_i)
            };
         end

         if (w_in_hs) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= data_i;
         end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
         end

         if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_act;
         end else if (ready_i) begin
            r_s2_valid <= 1'b0;
         end

         if (w_cfg_accept)
            r_cnt <= '0;
         else if (w_out_hs)
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

`ifdef ITA_ACT_SAT_CNT_EN
   localparam int c_sat_sum_w = $clog2(N + 1);

   logic [N-1:0]             w_lane_sat;
   logic [c_sat_sum_w-1:0]   w_sat_sum;
   logic [16:0]              w_sat_next;
   logic [15:0]              r_sat_cnt;

   for (genvar i = 0; i < int'(N); i++) begin : g_sat
      gelu_wide_t w_presat;
      assign w_presat = gelu_presat(r_s1_data[i], r_cfg.one, r_cfg.b, r_cfg.c,
                                    r_cfg.eps_mult, r_cfg.right_shift, r_cfg.add);
      assign w_lane_sat[i] = (w_presat > c_requant_max) || (w_presat < c_requant_min);
   end

   always_comb begin
      w_sat_sum = '0;
      for (int i = 0; i < int'(N); i++)
         w_sat_sum = w_sat_sum + c_sat_sum_w'(w_lane_sat[i]);
      w_sat_next = {1'b0, r_sat_cnt} + 17'(w_sat_sum);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         r_sat_cnt <= '0;
      else if (w_cfg_accept)
         r_sat_cnt <= '0;
      else if (w_s1_adv && (r_cfg.mode == ACT_GELU))
         r_sat_cnt <= w_sat_next[16] ? 16'hFFFF : w_sat_next[15:0];
   end

   assign sat_cnt_o = r_sat_cnt;
`else
   assign sat_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ita_activation.sv
`default_nettype none
// ============================================================================
// Module   : tb_ita_activation
// Brief    : Directed self-checking bench for ita_activation.
// Revision : 1.0
// ============================================================================
module tb_ita_activation;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              cfg_we_i;
   logic [1:0]        cfg_mode_i;
   logic [15:0]       cfg_one_i, cfg_b_i, cfg_c_i;
   logic [7:0]        cfg_eps_mult_i, cfg_right_shift_i, cfg_add_i;
   logic [15:0]       cfg_len_i;
   logic              cfg_err_o;
   logic              valid_i, ready_o, valid_o, ready_i, last_o, busy_o;
   logic [15:0][7:0]  data_i, data_o;
   logic [15:0]       sat_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   ita_activation #(.N(16), .CNT_W(16)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .cfg_we_i          (cfg_we_i),
      .cfg_mode_i        (cfg_mode_i),
      .cfg_one_i         (cfg_one_i),
      .cfg_b_i           (cfg_b_i),
      .cfg_c_i           (cfg_c_i),
      .cfg_eps_mult_i    (cfg_eps_mult_i),
      .cfg_right_shift_i (cfg_right_shift_i),
      .cfg_add_i         (cfg_add_i),
      .cfg_len_i         (cfg_len_i),
      .cfg_err_o         (cfg_err_o),
      .valid_i           (valid_i),
      .ready_o           (ready_o),
      .data_i            (data_i),
      .valid_o           (valid_o),
      .ready_i           (ready_i),
      .data_o            (data_o),
      .last_o            (last_o),
      .busy_o            (busy_o),
      .sat_cnt_o         (sat_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] fill(input logic [7:0] v);
      return {16{v}};
   endfunction

   function automatic logic [127:0] lanes8(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {64'h0, a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic do_cfg(input logic [1:0] m, input logic [15:0] one, b, c,
                         input logic [7:0] eps, sh, add, input logic [15:0] len);
      cfg_mode_i = m; cfg_one_i = one; cfg_b_i = b; cfg_c_i = c;
      cfg_eps_mult_i = eps; cfg_right_shift_i = sh; cfg_add_i = add; cfg_len_i = len;
      cfg_we_i = 1'b1;
      @(posedge clk_i); #1;
      cfg_we_i = 1'b0;
      chk("cfg_accept", cfg_err_o, 0);
   endtask

   task automatic send_one(input logic [127:0] d, output logic [127:0] q, output logic l);
      int k;
      valid_i = 1'b1; data_i = d;
      @(posedge clk_i); #1;
      valid_i = 1'b0; data_i = '0;
      k = 0;
      while (!valid_o && k < 10) begin
         @(posedge clk_i); #1;
         k++;
      end
      chk("out_timeout", valid_o, 1);
      q = data_o; l = last_o;
      @(posedge clk_i); #1;
   endtask

   initial begin : main
      logic [127:0] q, e;
      logic         l;
      int           sent, rcv;

      rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_mode_i = '0; cfg_one_i = '0; cfg_b_i = '0;
      cfg_c_i = '0; cfg_eps_mult_i = '0; cfg_right_shift_i = '0; cfg_add_i = '0;
      cfg_len_i = '0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      #1;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_ready_o", ready_o, 1);
      chk("rst_data_o", data_o, 0);
      chk("rst_last_o", last_o, 0);
      chk("rst_busy_o", busy_o, 0);
      chk("rst_cfg_err", cfg_err_o, 0);
      chk("rst_sat_cnt", sat_cnt_o, 0);
      @(posedge clk_i); #1;

      // Identity streaming, len 4
      do_cfg(2'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 16'd4);
      for (int j = 0; j < 10; j++) begin
         valid_i = (j < 8);
         data_i  = (j < 8) ? fill(8'(j)) : '0;
         #1;
         if (j >= 2) begin
            chk("id_valid", valid_o, 1);
            chk("id_data", data_o, fill(8'(j - 2)));
            chk("id_last", last_o, ((j - 2) % 4 == 3));
         end else begin
            chk("id_latency", valid_o, 0);
         end
         chk("id_ready", ready_o, 1);
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0;
      chk("id_drain", valid_o, 0);

      // ReLU and reserved mode
      do_cfg(2'd1, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 16'd1);
      send_one(lanes8(8'hFB, 8'h00, 8'h07, 8'h80, 8'h01, 8'hFF, 8'h7F, 8'h00), q, l);
      chk("relu_data", q, lanes8(8'h00, 8'h00, 8'h07, 8'h00, 8'h01, 8'h00, 8'h7F, 8'h00));
      chk("relu_last", l, 1);
      do_cfg(2'd3, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 16'd1);
      send_one(lanes8(8'hFB, 8'h00, 8'h07, 8'h80, 8'h01, 8'hFF, 8'h7F, 8'h00), q, l);
      chk("rsv_data", q, lanes8(8'hFB, 8'h00, 8'h07, 8'h80, 8'h01, 8'hFF, 8'h7F, 8'h00));

      // GELU: one=16 b=-4 c=14 eps=1 shift=2
      do_cfg(2'd2, 16'd16, 16'hFFFC, 16'd14, 8'd1, 8'd2, 8'd0, 16'd1);
      send_one(lanes8(8'd2, 8'hFE, 8'd1, 8'hFF, 8'd0, 8'h80, 8'h81, 8'd3), q, l);
      chk("gelu_data", q, lanes8(8'd17, 8'd1, 8'd10, 8'd2, 8'd0, 8'hC0, 8'hC0, 8'd23));
      chk("gelu_nosat", sat_cnt_o, 0);

      // GELU with shift 0 saturates both ends
      do_cfg(2'd2, 16'd16, 16'hFFFC, 16'd14, 8'd1, 8'd0, 8'd0, 16'd1);
      send_one(lanes8(8'h7F, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), q, l);
      chk("gelu_sat_data", q, lanes8(8'h7F, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
`ifdef ITA_ACT_SAT_CNT_EN
      chk("gelu_sat_cnt", sat_cnt_o, 2);
`else
      chk("gelu_sat_cnt", sat_cnt_o, 0);
`endif

      // GELU with offset add=-3
      do_cfg(2'd2, 16'd16, 16'hFFFC, 16'd14, 8'd1, 8'd2, 8'hFD, 16'd1);
      send_one(lanes8(8'd2, 8'hFE, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), q, l);
      e = fill(8'hFD);
      e[7:0]  = 8'h0E;
      e[15:8] = 8'hFE;
      chk("gelu_add", q, e);

      // len 0 behaves as len 1
      do_cfg(2'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 16'd0);
      send_one(fill(8'h44), q, l);
      chk("len0_last_a", l, 1);
      send_one(fill(8'h45), q, l);
      chk("len0_last_b", l, 1);

      // Backpressure: ready_i low for cycles 4..8
      do_cfg(2'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 16'd4);
      sent = 0; rcv = 0;
      for (int cyc = 0; cyc < 22; cyc++) begin
         ready_i = !(cyc >= 4 && cyc < 9);
         valid_i = (sent < 10);
         data_i  = fill(8'(8'h20 + sent));
         #1;
         if (!ready_i) begin
            chk("bp_ready_o", ready_o, 0);
            chk("bp_hold", data_o, fill(8'h22));
            chk("bp_valid", valid_o, 1);
            chk("bp_occupancy", sent - rcv, 2);
         end
         if (valid_o && ready_i) begin
            chk("bp_data", data_o, fill(8'(8'h20 + rcv)));
            chk("bp_last", last_o, (rcv % 4 == 3));
            rcv++;
         end
         if (valid_i && ready_o) sent++;
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0; ready_i = 1'b1;
      chk("bp_count", rcv, 10);
      chk("bp_empty", busy_o, 0);

      // Rejected config while busy; counter sits at 2 of len 4
      valid_i = 1'b1; data_i = fill(8'hFD);
      @(posedge clk_i); #1;
      valid_i = 1'b0; data_i = '0;
      cfg_mode_i = 2'd1; cfg_len_i = 16'd1; cfg_we_i = 1'b1;
      #1;
      chk("rej_busy", busy_o, 1);
      @(posedge clk_i); #1;
      cfg_we_i = 1'b0;
      chk("rej_err", cfg_err_o, 1);
      chk("rej_valid", valid_o, 1);
      chk("rej_data", data_o, fill(8'hFD));
      chk("rej_last", last_o, 0);
      @(posedge clk_i); #1;
      chk("rej_err_clr", cfg_err_o, 0);

      // Reset with both stages full
      do_cfg(2'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 16'd3);
      ready_i = 1'b0; valid_i = 1'b1; data_i = fill(8'h11);
      @(posedge clk_i); #1;
      data_i = fill(8'h12);
      @(posedge clk_i); #1;
      valid_i = 1'b0; data_i = '0;
      chk("rst_full", {busy_o, valid_o, ready_o}, 3'b110);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1; ready_i = 1'b1;
      #1;
      chk("mrst_valid", valid_o, 0);
      chk("mrst_busy", busy_o, 0);
      chk("mrst_data", data_o, 0);
      repeat (3) @(posedge clk_i);
      #1;
      chk("mrst_quiet", valid_o, 0);
      send_one(fill(8'h33), q, l);
      chk("mrst_def_data", q, fill(8'h33));
      chk("mrst_def_last", l, 1);
      do_cfg(2'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 16'd3);
      for (int k = 0; k < 3; k++) begin
         send_one(fill(8'(8'h50 + k)), q, l);
         chk("tile_data", q, fill(8'(8'h50 + k)));
         chk("tile_last", l, (k == 2));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
